// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Serial transmitter placed directly after the UART register block. A rising
// edge on tx_start while idle launches one frame: one start bit (low), then
// DATA_BITS data bits LSB first, then one stop bit (high). There is no parity.
// Each bit lasts OVERSAMPLE baud ticks, and one baud tick lasts dvsr+1 clocks.
//
// Parameters
//   DATA_BITS   data bits per frame
//   OVERSAMPLE  baud ticks per bit period
//   DVSR_W      width of the baud divisor input
//
// Ports
//   clk           system clock; all logic runs on the rising edge
//   rst_n         asynchronous active-low reset
//   tx_start      level from the register block; a rising edge while idle
//                 requests one frame. Edges seen mid-frame are dropped.
//   data_in       byte to send; sampled only in the launch cycle
//   dvsr          baud divisor; sampled only in the launch cycle
//   tx            serial line; idle high; driven straight from a flop
//   tx_done       high while idle/ready; low for the whole frame
//   tx_done_tick  one-cycle pulse in the first idle cycle after the stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DVSR_W     = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic [DVSR_W-1:0]    dvsr,
    output logic                 tx,
    output logic                 tx_done,
    output logic                 tx_done_tick
);

    // Counter widths. The guards keep the widths legal for degenerate values
    // of 1, where $clog2 would return 0.
    localparam int S_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_reg, state_next;
    logic [DVSR_W-1:0]     dvsr_reg, dvsr_next;     // divisor latched at launch
    logic [DVSR_W-1:0]     baud_reg, baud_next;     // 0..dvsr_reg
    logic [S_W-1:0]        s_reg, s_next;           // ticks within a bit
    logic [N_W-1:0]        n_reg, n_next;           // data bit index
    logic [DATA_BITS-1:0]  shift_reg, shift_next;   // outgoing data, LSB first
    logic                  tx_reg, tx_next;
    logic                  done_reg, done_next;
    logic                  done_tick_reg, done_tick_next;
    logic                  start_q_reg;             // tx_start from last cycle

    // Decoded events
    logic                  launch;
    logic                  baud_tick;
    logic                  bit_end;
    logic [DATA_BITS-1:0]  shift_dn;

    // Resetting start_q_reg to 1 means a tx_start that is still high when
    // reset is released does not look like a rising edge.
    assign launch    = tx_start & ~start_q_reg & (state_reg == IDLE);

    // The divisor counter is held at zero while idle, so baud_tick cannot
    // fire outside a frame.
    assign baud_tick = (state_reg != IDLE) && (baud_reg == dvsr_reg);
    assign bit_end   = baud_tick && (s_reg == S_LAST);

    // Shift-right of the data register. A zero fills the MSB.
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            if (gi == DATA_BITS - 1) begin : g_msb
                assign shift_dn[gi] = 1'b0;
            end else begin : g_lower
                assign shift_dn[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequential part
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            dvsr_reg      <= '0;
            baud_reg      <= '0;
            s_reg         <= '0;
            n_reg         <= '0;
            shift_reg     <= '0;
            tx_reg        <= 1'b1;
            done_reg      <= 1'b1;
            done_tick_reg <= 1'b0;
            start_q_reg   <= 1'b1;
        end else begin
            state_reg     <= state_next;
            dvsr_reg      <= dvsr_next;
            baud_reg      <= baud_next;
            s_reg         <= s_next;
            n_reg         <= n_next;
            shift_reg     <= shift_next;
            tx_reg        <= tx_next;
            done_reg      <= done_next;
            done_tick_reg <= done_tick_next;
            start_q_reg   <= tx_start;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counters and registered-output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        dvsr_next      = dvsr_reg;
        baud_next      = baud_reg;
        s_next         = s_reg;
        n_next         = n_reg;
        shift_next     = shift_reg;
        done_tick_next = 1'b0;

        // Baud and tick counters run only inside a frame. At a bit end the
        // tick counter wraps to zero explicitly, so OVERSAMPLE does not have
        // to be a power of two.
        if (state_reg != IDLE) begin
            if (baud_tick) begin
                baud_next = '0;
                s_next    = bit_end ? '0 : s_reg + 1'b1;
            end else begin
                baud_next = baud_reg + 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (launch) begin
                    state_next = START;
                    shift_next = data_in;
                    dvsr_next  = dvsr;
                    baud_next  = '0;
                    s_next     = '0;
                    n_next     = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    n_next     = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_dn;
                    if (n_reg == N_LAST) begin
                        state_next = STOP;
                    end else begin
                        n_next = n_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next     = IDLE;
                    done_tick_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // tx and tx_done are decoded from the next state and registered. The pins
    // then come straight from flops and show the state entered on the same
    // edge, without any glitches.
    always_comb begin
        tx_next   = 1'b1;
        done_next = (state_next == IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx           = tx_reg;
    assign tx_done      = done_reg;
    assign tx_done_tick = done_tick_reg;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that sits directly downstream of the UART register block.
- Consumes the register block's transmit byte (data_out), baud divisor (dvsr) and start control (tx_start).
- Returns tx_done, which the register block uses to gate writes and clear its full bit.
- Produces an 8N1 frame on the tx pin: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity.

Parameters:
DATA_BITS, 8, data bits per frame
OVERSAMPLE, 16, baud ticks per bit period
DVSR_W, 11, width of the divisor input

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
tx_start  input  1  level from register block; a rising edge requests one frame
data_in  input  DATA_BITS  byte to transmit; sampled at frame launch
dvsr  input  DVSR_W  baud divisor; tick period = dvsr+1 clocks; sampled at frame launch
tx  output  1  serial line, idle high
tx_done  output  1  high while idle/ready; low for the whole frame
tx_done_tick  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - tx=1, tx_done=1, tx_done_tick=0.
  - State IDLE; baud counter, tick counter and bit counter all 0.
  - Shift register 0.
  - tx_start_q (previous-value flop) resets to 1, so a tx_start held high through reset launches no frame.
- Start detect: launch = tx_start & ~tx_start_q & (state==IDLE). tx_start_q updates every cycle.
- Rising edges while not IDLE are ignored and lost, not queued.
- Launch cycle N:
  - data_in is latched into the shift register and dvsr into dvsr_l.
  - Counters clear; state becomes START at N+1.
  - At N+1: tx=0, tx_done=0.
- Baud tick: counter runs 0..dvsr_l; tick is asserted in the cycle where counter==dvsr_l, and the counter then wraps to 0.
  - dvsr_l=0 gives a tick every clock.
  - Counting is active only outside IDLE.
- Bit timing: the s counter (0..OVERSAMPLE-1) advances on each tick. A bit ends on the tick where s==OVERSAMPLE-1.
  - Each bit therefore lasts exactly OVERSAMPLE*(dvsr_l+1) clocks.
- State machine (transitions at bit end):
  - IDLE: tx=1, tx_done=1; -> START on launch.
  - START: tx=0; -> DATA, bit counter n=0.
  - DATA: tx = shift[0]. At bit end the shift register shifts right. If n==DATA_BITS-1 go to STOP, else n increments.
  - STOP: tx=1; at bit end -> IDLE with tx_done_tick=1 for that single cycle. tx_done=1 from the first IDLE cycle.
- Frame length: (DATA_BITS+2)*OVERSAMPLE*(dvsr_l+1) clocks from START entry to IDLE re-entry.
- tx is a registered output: a decoded state/shift flop, glitch-free.
- Input changes mid-frame: changes to data_in or dvsr after launch have no effect on the current frame.
- Back-to-back frames: a new rising edge is honoured in any IDLE cycle, including the first one after STOP.
  - Minimum inter-frame gap is therefore 1 idle cycle (tx high).
- Reset mid-frame: immediate return to reset values. The partial frame is truncated and tx goes high at once.
- dvsr at maximum (all ones): frame still completes. Counter widths hold the value without overflow.

Test Plan:
- Reset then idle: hold rst_n low 3 cycles, release with tx_start=0 -> tx=1, tx_done=1, tx_done_tick=0 for 50 cycles.
- Single frame: dvsr=0, data_in=0xA5, tx_start 0->1 -> tx=0 from the cycle after launch. Then, in 16-clock slots: 1,0,1,0,0,1,0,1, then stop 1. tx_done low for exactly 160 cycles; tx_done_tick pulses once at the end.
- Divisor scaling: dvsr=3, data_in=0x00 -> each bit 64 clocks; tx low for 576 clocks (start + 8 zeros); tx_done low for 640 clocks.
- Mid-frame changes: launch 0x55 with dvsr=0. In DATA, change data_in to 0xFF and dvsr to 5, and toggle tx_start 0->1 -> frame still 0x55 at 16 clocks/bit, and no second frame follows.
- Back-to-back: re-raise tx_start in the first idle cycle after tx_done_tick -> second frame starts. tx stays high 1 cycle between the stop bit and the next start bit.
- Reset mid-frame: assert rst_n low during data bit 3 -> tx=1 and tx_done=1 immediately. With tx_start still high at release, no frame is launched.
